// File: rtl/img_scale_addr_gen_pkg.sv
// Shared definitions for the scaled-image address generator: mode
// encodings, default geometry and the log2 scale-factor clamp.
package img_scale_pkg;

  typedef enum logic [1:0] {
    MODE_ID  = 2'b00,
    MODE_IN  = 2'b01,
    MODE_OUT = 2'b10
  } mode_e;

  localparam int IMG_W_DEF    = 160;
  localparam int IMG_H_DEF    = 120;
  localparam int SCR_W_DEF    = 640;
  localparam int SCR_H_DEF    = 480;
  localparam int MAX_LOG2_DEF = 2;

  // Largest usable log2 factor not above the request: a zoom-in window
  // must fit on screen, a zoom-out window must keep at least one pixel.
  // max_log2 is expected to be <= 3 (2-bit factor field).
  function automatic logic [1:0] clamp_log2(input mode_e mode,
                                            input logic [1:0] req,
                                            input int img_w, input int img_h,
                                            input int scr_w, input int scr_h,
                                            input int max_log2);
    int k;
    k = (int'(req) > max_log2) ? max_log2 : int'(req);
    case (mode)
      MODE_IN: begin
        for (int i = 0; i < 4; i++)
          if (k > 0 && (((img_w << k) > scr_w) || ((img_h << k) > scr_h)))
            k = k - 1;
      end
      MODE_OUT: begin
        for (int i = 0; i < 4; i++)
          if (k > 0 && (((img_w >> k) < 1) || ((img_h >> k) < 1)))
            k = k - 1;
      end
      default: k = 0;
    endcase
    return k[1:0];
  endfunction

endpackage

// File: rtl/img_scale_addr_gen_if.sv
// Scan-coordinate / request inputs and address / status outputs of the
// scaled-image address generator. master drives scan coordinates, slave
// is the generator.
interface img_scale_addr_gen_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 19
);
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic [1:0]         mode_req;
  logic [1:0]         log2_req;
  logic               mirror_h;
  logic [ADDR_W-1:0]  rd_addr;
  logic               in_image;
  logic [1:0]         mode_act;
  logic [1:0]         log2_act;
  logic               frame_tick;

  modport master (
    output next_x, next_y, mode_req, log2_req, mirror_h,
    input  rd_addr, in_image, mode_act, log2_act, frame_tick
  );

  modport slave (
    input  next_x, next_y, mode_req, log2_req, mirror_h,
    output rd_addr, in_image, mode_act, log2_act, frame_tick
  );
endinterface

// File: rtl/img_scale_addr_gen_cfg.sv
// Frame-boundary shadow register for the scaler configuration. Requests
// are sampled only when the scan is at (0,0); the *_eff outputs already
// reflect a load happening this cycle so the (0,0) pixel uses it.
// Optional feature macro: IMG_SCALE_MIRROR_EN (shadows mirror_h).
module img_scale_cfg
  import img_scale_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int SCR_W    = SCR_W_DEF,
  parameter int SCR_H    = SCR_H_DEF,
  parameter int COORD_W  = 10,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] next_x,
  input  logic [COORD_W-1:0] next_y,
  input  logic [1:0]         mode_req,
  input  logic [1:0]         log2_req,
`ifdef IMG_SCALE_MIRROR_EN
  input  logic               mirror_req,
  output logic               mirror_eff,
`endif
  output mode_e              mode_eff,
  output logic [1:0]         k_eff,
  output logic [COORD_W-1:0] w_eff,
  output logic [COORD_W-1:0] h_eff,
  output logic [COORD_W-1:0] x_off_eff,
  output logic [COORD_W-1:0] y_off_eff,
  output logic [1:0]         mode_act,
  output logic [1:0]         log2_act,
  output logic               frame_tick
);

  logic               load;
  mode_e              mode_n, mode_d, mode_q;
  logic [1:0]         k_n, k_d, k_q;
  logic [COORD_W-1:0] w_n, h_n, xo_n, yo_n;
  logic [COORD_W-1:0] w_d, h_d, xo_d, yo_d;
  logic [COORD_W-1:0] w_q, h_q, xo_q, yo_q;
  logic               tick_d, tick_q;
  int                 w_i, h_i;
`ifdef IMG_SCALE_MIRROR_EN
  logic               mirror_d, mirror_q;
`endif

  assign load = (next_x == '0) && (next_y == '0);

  // Candidate configuration derived from the live requests
  always_comb begin
    case (mode_req)
      2'b01:   mode_n = MODE_IN;
      2'b10:   mode_n = MODE_OUT;
      default: mode_n = MODE_ID;
    endcase
    k_n = clamp_log2(mode_n, log2_req, IMG_W, IMG_H, SCR_W, SCR_H, MAX_LOG2);
    w_i = IMG_W;
    h_i = IMG_H;
    case (mode_n)
      MODE_IN: begin
        w_i = IMG_W << k_n;
        h_i = IMG_H << k_n;
      end
      MODE_OUT: begin
        w_i = IMG_W >> k_n;
        h_i = IMG_H >> k_n;
      end
      default: ;
    endcase
    w_n  = COORD_W'(w_i);
    h_n  = COORD_W'(h_i);
    xo_n = COORD_W'((SCR_W - w_i) >> 1);
    yo_n = COORD_W'((SCR_H - h_i) >> 1);
  end

  // Hold the shadow copy except on the (0,0) load cycle
  always_comb begin
    mode_d = mode_q;
    k_d    = k_q;
    w_d    = w_q;
    h_d    = h_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    tick_d = 1'b0;
`ifdef IMG_SCALE_MIRROR_EN
    mirror_d = mirror_q;
`endif
    if (load) begin
      mode_d = mode_n;
      k_d    = k_n;
      w_d    = w_n;
      h_d    = h_n;
      xo_d   = xo_n;
      yo_d   = yo_n;
      tick_d = 1'b1;
`ifdef IMG_SCALE_MIRROR_EN
      mirror_d = mirror_req;
`endif
    end
  end

  // Shadow registers; reset restores the centred identity mapping
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= MODE_ID;
      k_q    <= '0;
      w_q    <= COORD_W'(IMG_W);
      h_q    <= COORD_W'(IMG_H);
      xo_q   <= COORD_W'((SCR_W - IMG_W) / 2);
      yo_q   <= COORD_W'((SCR_H - IMG_H) / 2);
      tick_q <= 1'b0;
`ifdef IMG_SCALE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      mode_q <= mode_d;
      k_q    <= k_d;
      w_q    <= w_d;
      h_q    <= h_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      tick_q <= tick_d;
`ifdef IMG_SCALE_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  assign mode_eff   = mode_d;
  assign k_eff      = k_d;
  assign w_eff      = w_d;
  assign h_eff      = h_d;
  assign x_off_eff  = xo_d;
  assign y_off_eff  = yo_d;
`ifdef IMG_SCALE_MIRROR_EN
  assign mirror_eff = mirror_d;
`endif
  assign mode_act   = mode_q;
  assign log2_act   = k_q;
  assign frame_tick = tick_q;

endmodule

// File: rtl/img_scale_addr_gen.sv
// Maps VGA scan coordinates to framebuffer read addresses for a centred,
// power-of-two scaled image. Two-stage pipeline: window test / relative
// coordinates, then source coordinates / linear address.
// Optional feature macro: IMG_SCALE_MIRROR_EN (horizontal mirror).
module img_scale_addr_gen
  import img_scale_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int SCR_W    = SCR_W_DEF,
  parameter int SCR_H    = SCR_H_DEF,
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 19,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input logic                clock,
  input logic                reset,
  img_scale_addr_gen_if.slave io
);

  localparam int STAGES = 2;

  mode_e              mode_eff;
  logic [1:0]         k_eff;
  logic [COORD_W-1:0] w_eff, h_eff, x_off, y_off;
`ifdef IMG_SCALE_MIRROR_EN
  logic               mirror_eff;
  logic               mirror_s1_d, mirror_s1_q;
`endif

  logic [STAGES-1:0]  vld_d, vld_q;
  logic               win_s1_d, win_s1_q;
  logic [COORD_W-1:0] rel_x_s1_d, rel_x_s1_q, rel_y_s1_d, rel_y_s1_q;
  mode_e              mode_s1_d, mode_s1_q;
  logic [1:0]         k_s1_d, k_s1_q;
  logic [COORD_W-1:0] src_x, src_y;
  logic               win_s2_d, win_s2_q;
  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic               in_scr, in_x, in_y;

  img_scale_cfg #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .COORD_W(COORD_W), .MAX_LOG2(MAX_LOG2)
  ) u_cfg (
    .clock      (clock),
    .reset      (reset),
    .next_x     (io.next_x),
    .next_y     (io.next_y),
    .mode_req   (io.mode_req),
    .log2_req   (io.log2_req),
`ifdef IMG_SCALE_MIRROR_EN
    .mirror_req (io.mirror_h),
    .mirror_eff (mirror_eff),
`endif
    .mode_eff   (mode_eff),
    .k_eff      (k_eff),
    .w_eff      (w_eff),
    .h_eff      (h_eff),
    .x_off_eff  (x_off),
    .y_off_eff  (y_off),
    .mode_act   (io.mode_act),
    .log2_act   (io.log2_act),
    .frame_tick (io.frame_tick)
  );

  assign vld_d = {vld_q[STAGES-2:0], 1'b1};

  // Stage 1: window test and window-relative coordinates; the pixel's
  // scale settings travel with it so in-flight pixels keep the old mode
  always_comb begin
    in_scr = (int'(io.next_x) < SCR_W) && (int'(io.next_y) < SCR_H);
    in_x   = (io.next_x >= x_off) &&
             ({1'b0, io.next_x} < ({1'b0, x_off} + {1'b0, w_eff}));
    in_y   = (io.next_y >= y_off) &&
             ({1'b0, io.next_y} < ({1'b0, y_off} + {1'b0, h_eff}));
    win_s1_d   = in_scr && in_x && in_y;
    rel_x_s1_d = io.next_x - x_off;
    rel_y_s1_d = io.next_y - y_off;
    mode_s1_d  = mode_eff;
    k_s1_d     = k_eff;
`ifdef IMG_SCALE_MIRROR_EN
    mirror_s1_d = mirror_eff;
`endif
  end

  // Stage 2: source pixel and linear address (zero outside the window)
  always_comb begin
    src_x = rel_x_s1_q;
    src_y = rel_y_s1_q;
    case (mode_s1_q)
      MODE_IN: begin
        src_x = rel_x_s1_q >> k_s1_q;
        src_y = rel_y_s1_q >> k_s1_q;
      end
      MODE_OUT: begin
        src_x = rel_x_s1_q << k_s1_q;
        src_y = rel_y_s1_q << k_s1_q;
      end
      default: ;
    endcase
`ifdef IMG_SCALE_MIRROR_EN
    if (mirror_s1_q)
      src_x = COORD_W'(IMG_W - 1) - src_x;
`endif
    win_s2_d = win_s1_q && vld_q[0];
    addr_d   = '0;
    if (win_s2_d)
      addr_d = ADDR_W'(src_y) * ADDR_W'(IMG_W) + ADDR_W'(src_x);
  end

  // Pipeline registers
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q      <= '0;
      win_s1_q   <= 1'b0;
      rel_x_s1_q <= '0;
      rel_y_s1_q <= '0;
      mode_s1_q  <= MODE_ID;
      k_s1_q     <= '0;
      win_s2_q   <= 1'b0;
      addr_q     <= '0;
`ifdef IMG_SCALE_MIRROR_EN
      mirror_s1_q <= 1'b0;
`endif
    end else begin
      vld_q      <= vld_d;
      win_s1_q   <= win_s1_d;
      rel_x_s1_q <= rel_x_s1_d;
      rel_y_s1_q <= rel_y_s1_d;
      mode_s1_q  <= mode_s1_d;
      k_s1_q     <= k_s1_d;
      win_s2_q   <= win_s2_d;
      addr_q     <= addr_d;
`ifdef IMG_SCALE_MIRROR_EN
      mirror_s1_q <= mirror_s1_d;
`endif
    end
  end

  assign io.rd_addr  = addr_q;
  assign io.in_image = win_s2_q && vld_q[STAGES-1];

endmodule

// File: tb/tb_img_scale_addr_gen.sv
// Randomised bench for img_scale_addr_gen against a frame-level
// arithmetic reference model (scale factor, window, offsets).
module tb_img_scale_addr_gen;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int MAXL  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #20 clock = ~clock;

  img_scale_addr_gen_if #(.COORD_W(10), .ADDR_W(19)) io ();

  img_scale_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .COORD_W(10), .ADDR_W(19), .MAX_LOG2(MAXL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;

  // reference state: applied mode / factor / mirror, and the result of
  // the previous cycle's pixel (output appears two edges later)
  int m_mode = 0, m_k = 0, m_mir = 0;
  int p1_addr = 0, p1_in = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_load(input int m, input int l, input int mir);
    int s;
    m_mode = (m == 1 || m == 2) ? m : 0;
    m_k    = 0;
    if (m_mode != 0) begin
      m_k = (l > MAXL) ? MAXL : l;
      s = 1 << m_k;
      if (m_mode == 1)
        while (m_k > 0 && (IMG_W * s > SCR_W || IMG_H * s > SCR_H)) begin
          m_k--; s = 1 << m_k;
        end
      else
        while (m_k > 0 && (IMG_W / s == 0 || IMG_H / s == 0)) begin
          m_k--; s = 1 << m_k;
        end
    end
`ifdef IMG_SCALE_MIRROR_EN
    m_mir = mir;
`else
    m_mir = 0;
    if (mir < 0) m_mir = 0;
`endif
  endfunction

  function automatic void model_pix(input int x, input int y,
                                    output int addr, output int inim);
    int s, w, h, xo, yo, sx, sy;
    s = 1 << m_k;
    w = IMG_W; h = IMG_H;
    if (m_mode == 1) begin w = IMG_W * s; h = IMG_H * s; end
    if (m_mode == 2) begin w = IMG_W / s; h = IMG_H / s; end
    xo = (SCR_W - w) / 2;
    yo = (SCR_H - h) / 2;
    inim = (x < SCR_W && y < SCR_H && x >= xo && x < xo + w &&
            y >= yo && y < yo + h) ? 1 : 0;
    addr = 0;
    if (inim == 1) begin
      sx = x - xo; sy = y - yo;
      if (m_mode == 1) begin sx = sx / s; sy = sy / s; end
      if (m_mode == 2) begin sx = sx * s; sy = sy * s; end
      if (m_mir == 1) sx = IMG_W - 1 - sx;
      addr = sy * IMG_W + sx;
    end
  endfunction

  // one scan cycle: drive at negedge, compare #1 after the rising edge
  task automatic step(input int x, input int y, input int m, input int l,
                      input int mir, input int rst);
    int now_addr, now_in, ld;
    @(negedge clock);
    io.next_x   = 10'(x);
    io.next_y   = 10'(y);
    io.mode_req = 2'(m);
    io.log2_req = 2'(l);
    io.mirror_h = 1'(mir);
    reset       = 1'(rst);
    ld = (rst == 0 && x == 0 && y == 0) ? 1 : 0;
    if (rst != 0) begin
      m_mode = 0; m_k = 0; m_mir = 0;
    end else if (ld == 1) begin
      model_load(m, l, mir);
    end
    model_pix(x, y, now_addr, now_in);
    @(posedge clock);
    #1;
    chk("rd_addr",    io.rd_addr,    (rst != 0) ? 0 : p1_addr);
    chk("in_image",   io.in_image,   (rst != 0) ? 0 : p1_in);
    chk("mode_act",   io.mode_act,   m_mode);
    chk("log2_act",   io.log2_act,   m_k);
    chk("frame_tick", io.frame_tick, ld);
    p1_addr = (rst != 0) ? 0 : now_addr;
    p1_in   = (rst != 0) ? 0 : now_in;
  endtask

  task automatic flush();
    step(700, 500, 3, 3, 1, 0);
    step(700, 500, 3, 3, 1, 0);
  endtask

  initial begin
    int x, y, r;
    io.next_x = 10'd5; io.next_y = 10'd5;
    io.mode_req = 2'b00; io.log2_req = 2'b00; io.mirror_h = 1'b0;

    // reset with non-zero coordinates
    repeat (3) step(7, 3, 1, 1, 1, 1);

    // identity after reset
    step(240, 180, 1, 2, 0, 0);
    step(399, 299, 2, 1, 0, 0);
    step(239, 180, 0, 0, 0, 0);
    flush();

    // zoom-in k=1
    step(0, 0, 1, 1, 0, 0);
    step(161, 121, 0, 0, 0, 0);
    step(162, 122, 0, 0, 0, 0);
    step(160, 120, 0, 0, 0, 0);
    step(479, 359, 0, 0, 0, 0);
    step(480, 359, 0, 0, 0, 0);
    flush();

    // zoom-out k=2
    step(0, 0, 2, 2, 0, 0);
    step(301, 226, 0, 0, 0, 0);
    step(304, 229, 0, 0, 0, 0);
    step(340, 230, 0, 0, 0, 0);
    step(339, 254, 0, 0, 0, 0);
    flush();

    // mid-frame request change is ignored until (0,0)
    step(100, 50, 1, 1, 1, 0);
    step(305, 230, 0, 3, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(200, 150, 1, 1, 0, 0);
    flush();

    // clamp: zoom-in 3 -> 2, full-screen window
    step(0, 0, 1, 3, 0, 0);
    step(639, 479, 0, 0, 0, 0);
    step(0, 479, 0, 0, 0, 0);
    step(640, 479, 0, 0, 0, 0);
    flush();

    // reset mid-line with a non-identity mode applied
    step(320, 240, 0, 0, 0, 0);
    step(321, 240, 0, 0, 0, 1);
    step(322, 240, 2, 2, 0, 0);
    step(240, 180, 2, 2, 0, 0);
    flush();

    // identity with mirror request
    step(0, 0, 0, 0, 1, 0);
    step(240, 180, 0, 0, 0, 0);
    step(399, 180, 0, 0, 0, 0);
    flush();

    // randomised frames, occasional resets and stray (0,x)/(x,0) points
    for (int f = 0; f < 24; f++) begin
      step(0, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 0);
      for (int i = 0; i < 160; i++) begin
        r = $urandom_range(0, 15);
        x = (r == 0) ? 0 : $urandom_range(0, 700);
        y = (r == 1) ? 0 : $urandom_range(0, 520);
        step(x, y, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 399) == 0) ? 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
